// File: rtl/blink_burst_gen.sv
// blink_burst_gen: NUM_CH independent blink generators sharing one period and
// burst-count configuration bus. Each channel latches its own copy of the
// configuration when started, then alternates ON/OFF phases of H cycles each,
// either forever (burst count 0) or for a finite number of blinks ending with
// a one-cycle done pulse.
//
// Control semantics (per channel n, sampled on every rising edge):
//   i_Stop[n]  : abort to IDLE, highest priority, never produces o_Done.
//   i_Start[n] : (re)start from the beginning of ON with freshly latched
//                configuration, from any state; suppresses a pending o_Done.
//   There is no backpressure: requests are single-cycle and always accepted.
module blink_burst_gen #(
   parameter int NUM_CH   = 4,
   parameter int PERIOD_W = 16,
   parameter int BURST_W  = 4
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst_L,
   input  logic [NUM_CH-1:0]     i_Start,
   input  logic [NUM_CH-1:0]     i_Stop,
   input  logic [PERIOD_W-1:0]   i_Half_Period,
   input  logic [BURST_W-1:0]    i_Burst_Count,
   output logic [NUM_CH-1:0]     o_Toggle,
   output logic [NUM_CH-1:0]     o_Busy,
   output logic [NUM_CH-1:0]     o_Done,
   output logic [2*NUM_CH-1:0]   o_Dbg_State
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_OFF  = 2'd2
   } state_e;

   // A zero half-period would never end a phase, so it is promoted to one cycle.
   logic [PERIOD_W-1:0] half_d;
   assign half_d = (i_Half_Period == '0) ? PERIOD_W'(1) : i_Half_Period;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      state_e              state_q;
      logic [PERIOD_W-1:0] cnt_q;
      logic [PERIOD_W-1:0] half_q;
      logic [BURST_W-1:0]  burst_q;
      logic [BURST_W-1:0]  remain_q;
      logic                toggle_q;
      logic                busy_q;
      logic                done_q;
      logic                phase_end_d;
      logic                last_blink_d;

      // Counter runs 0..H-1, so the compare never needs a wider counter.
      assign phase_end_d  = (cnt_q == half_q - PERIOD_W'(1));
      // Only finite bursts terminate; remaining count 1 means this OFF is the last.
      assign last_blink_d = (burst_q != '0) && (remain_q == BURST_W'(1));

      // Channel FSM with registered toggle/busy/done outputs.
      always_ff @(posedge i_Clk or negedge i_Rst_L) begin
         if (!i_Rst_L) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            half_q   <= '0;
            burst_q  <= '0;
            remain_q <= '0;
            toggle_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
         end else begin
            done_q <= 1'b0;
            if (i_Stop[g]) begin
               state_q  <= ST_IDLE;
               cnt_q    <= '0;
               toggle_q <= 1'b0;
               busy_q   <= 1'b0;
            end else if (i_Start[g]) begin
               state_q  <= ST_ON;
               cnt_q    <= '0;
               half_q   <= half_d;
               burst_q  <= i_Burst_Count;
               remain_q <= i_Burst_Count;
               toggle_q <= 1'b1;
               busy_q   <= 1'b1;
            end else begin
               case (state_q)
                  ST_ON: begin
                     if (phase_end_d) begin
                        state_q  <= ST_OFF;
                        cnt_q    <= '0;
                        toggle_q <= 1'b0;
                     end else begin
                        cnt_q <= cnt_q + PERIOD_W'(1);
                     end
                  end
                  ST_OFF: begin
                     if (phase_end_d) begin
                        cnt_q <= '0;
                        if (last_blink_d) begin
                           state_q  <= ST_IDLE;
                           remain_q <= '0;
                           busy_q   <= 1'b0;
                           done_q   <= 1'b1;
                        end else begin
                           if (burst_q != '0) begin
                              remain_q <= remain_q - BURST_W'(1);
                           end
                           state_q  <= ST_ON;
                           toggle_q <= 1'b1;
                        end
                     end else begin
                        cnt_q <= cnt_q + PERIOD_W'(1);
                     end
                  end
                  default: begin
                     state_q  <= ST_IDLE;
                     toggle_q <= 1'b0;
                     busy_q   <= 1'b0;
                  end
               endcase
            end
         end
      end

      assign o_Toggle[g]          = toggle_q;
      assign o_Busy[g]            = busy_q;
      assign o_Done[g]            = done_q;
      assign o_Dbg_State[2*g +: 2] = state_q;
   end

endmodule

// File: tb/tb_blink_burst_gen.sv
// Directed bench for blink_burst_gen. Expected output vectors come from a
// closed-form description of each channel's blink pattern since its last
// start, pushed to a queue as each step is driven and popped after the edge.
module tb_blink_burst_gen;
   localparam int NUM_CH   = 4;
   localparam int PERIOD_W = 16;
   localparam int BURST_W  = 4;
   localparam int W        = 3 * NUM_CH;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NUM_CH-1:0]     start_i;
   logic [NUM_CH-1:0]     stop_i;
   logic [PERIOD_W-1:0]   half_i;
   logic [BURST_W-1:0]    burst_i;
   logic [NUM_CH-1:0]     toggle_o;
   logic [NUM_CH-1:0]     busy_o;
   logic [NUM_CH-1:0]     done_o;
   logic [2*NUM_CH-1:0]   dbg_state_o;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [W-1:0] exp_q[$];
   string        tag_q[$];

   bit act[NUM_CH];
   int st_edge[NUM_CH];
   int hh[NUM_CH];
   int bb[NUM_CH];

   blink_burst_gen #(
      .NUM_CH   (NUM_CH),
      .PERIOD_W (PERIOD_W),
      .BURST_W  (BURST_W)
   ) dut (
      .i_Clk         (clk),
      .i_Rst_L       (rst_n),
      .i_Start       (start_i),
      .i_Stop        (stop_i),
      .i_Half_Period (half_i),
      .i_Burst_Count (burst_i),
      .o_Toggle      (toggle_o),
      .o_Busy        (busy_o),
      .o_Done        (done_o),
      .o_Dbg_State   (dbg_state_o)
   );

   // clock / reset
   always #5 clk = ~clk;

   // Expected {toggle, busy, done} after edge c, from the pattern since each start.
   function automatic logic [W-1:0] model_vec(input int c);
      logic [NUM_CH-1:0] t;
      logic [NUM_CH-1:0] b;
      logic [NUM_CH-1:0] d;
      int k;
      int per;
      t = '0;
      b = '0;
      d = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         if (act[ch] && c >= st_edge[ch]) begin
            k   = c - st_edge[ch];
            per = 2 * hh[ch];
            if (bb[ch] != 0 && k >= bb[ch] * per) begin
               d[ch] = (k == bb[ch] * per);
            end else begin
               b[ch] = 1'b1;
               t[ch] = ((k % per) < hh[ch]);
            end
         end
      end
      return {t, b, d};
   endfunction

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Drive one cycle of requests, predict, clock, compare.
   task automatic step(input string tag, input logic [NUM_CH-1:0] s, input logic [NUM_CH-1:0] p);
      start_i = s;
      stop_i  = p;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         if (p[ch]) begin
            act[ch] = 1'b0;
         end else if (s[ch]) begin
            act[ch]     = 1'b1;
            st_edge[ch] = cyc + 1;
            hh[ch]      = (half_i == '0) ? 1 : int'(half_i);
            bb[ch]      = int'(burst_i);
         end
      end
      exp_q.push_back(model_vec(cyc + 1));
      tag_q.push_back(tag);
      tick();
      start_i = '0;
      stop_i  = '0;
      check(tag_q.pop_front(), {toggle_o, busy_o, done_o}, exp_q.pop_front());
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag, '0, '0);
   endtask

   initial begin
      rst_n   = 1'b1;
      start_i = '0;
      stop_i  = '0;
      half_i  = '0;
      burst_i = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         act[ch] = 1'b0; st_edge[ch] = 0; hh[ch] = 1; bb[ch] = 0;
      end

      // asynchronous reset before any clock edge
      #2 rst_n = 1'b0;
      #1;
      check("reset_outputs", {toggle_o, busy_o, done_o}, '0);
      check("reset_state", W'(dbg_state_o), '0);
      tick();
      tick();
      check("reset_held", {toggle_o, busy_o, done_o}, '0);
      rst_n = 1'b1;

      // ch0 H=3 B=2, accepted on first edge after release; config change ignored
      half_i = 16'd3; burst_i = 4'd2;
      step("ch0_h3b2_start", 4'b0001, 4'b0000);
      half_i = 16'd7; burst_i = 4'd5;
      idle("ch0_h3b2", 14);

      // ch1 H=0 B=0: toggles every cycle until stop at edge 20
      half_i = 16'd0; burst_i = 4'd0;
      step("ch1_cont_start", 4'b0010, 4'b0000);
      idle("ch1_cont", 19);
      step("ch1_stop", 4'b0000, 4'b0010);
      idle("ch1_after_stop", 3);

      // ch0 H=4 and ch2 H=2 started five cycles apart
      half_i = 16'd4; burst_i = 4'd1;
      step("ch0_ch2_start0", 4'b0001, 4'b0000);
      half_i = 16'd2; burst_i = 4'd2;
      idle("ch0_ch2_gap", 4);
      step("ch0_ch2_start2", 4'b0100, 4'b0000);
      half_i = 16'd9; burst_i = 4'd7;
      idle("ch0_ch2_run", 12);

      // start+stop together on idle and busy channels
      step("startstop_idle", 4'b0001, 4'b0001);
      idle("startstop_idle_after", 2);
      half_i = 16'd3; burst_i = 4'd0;
      step("ch3_busy_start", 4'b1000, 4'b0000);
      idle("ch3_busy", 2);
      step("startstop_busy", 4'b1000, 4'b1000);
      idle("startstop_busy_after", 2);

      // ch3 H=5 B=3 restarted during OFF
      half_i = 16'd5; burst_i = 4'd3;
      step("ch3_h5b3_start", 4'b1000, 4'b0000);
      half_i = 16'd1; burst_i = 4'd1;
      idle("ch3_h5b3_run", 6);
      half_i = 16'd5; burst_i = 4'd3;
      step("ch3_restart_off", 4'b1000, 4'b0000);
      idle("ch3_h5b3_full", 32);

      // restart in the cycle the final OFF ends suppresses done
      half_i = 16'd1; burst_i = 4'd1;
      step("ch2_final_start", 4'b0100, 4'b0000);
      idle("ch2_final_on", 1);
      half_i = 16'd2; burst_i = 4'd1;
      step("ch2_restart_final", 4'b0100, 4'b0000);
      idle("ch2_restart_run", 5);

      // maximum burst count and maximum half period
      half_i = 16'd1; burst_i = 4'd15;
      step("ch1_bmax_start", 4'b0010, 4'b0000);
      idle("ch1_bmax", 31);
      half_i = 16'hFFFF; burst_i = 4'd1;
      step("ch0_hmax_start", 4'b0001, 4'b0000);
      idle("ch0_hmax", 5);
      step("ch0_hmax_stop", 4'b0000, 4'b0001);

      // asynchronous reset in the middle of ON
      half_i = 16'd3; burst_i = 4'd1;
      step("ch0_rst_start", 4'b0001, 4'b0000);
      idle("ch0_rst_on", 1);
      #3 rst_n = 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) act[ch] = 1'b0;
      #1;
      check("async_rst_mid_on", {toggle_o, busy_o, done_o}, '0);
      tick();
      rst_n = 1'b1;
      idle("after_rst_idle", 8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/blink_burst_gen.md
BLINK_BURST_GEN -- requirements
Module: blink_burst_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent channels (1..32).
REQ-002 SHALL have parameter PERIOD_W, default 16: width of the half-period value in clock cycles.
REQ-003 SHALL have parameter BURST_W, default 4: width of the burst-count value.
REQ-004 SHALL have port i_Clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 SHALL have port i_Rst_L  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_Start  input  NUM_CH  per-channel start request, sampled each cycle.
REQ-007 SHALL have port i_Stop  input  NUM_CH  per-channel abort request, sampled each cycle.
REQ-008 SHALL have port i_Half_Period  input  PERIOD_W  shared ON/OFF phase length, latched per channel on start.
REQ-009 SHALL have port i_Burst_Count  input  BURST_W  shared number of blinks, latched per channel on start; 0 = continuous.
REQ-010 SHALL have port o_Toggle  output  NUM_CH  registered blink output per channel.
REQ-011 SHALL have port o_Busy  output  NUM_CH  registered, high while the channel is not IDLE.
REQ-012 SHALL have port o_Done  output  NUM_CH  registered one-cycle pulse when a finite burst completes.

Function
REQ-013 Each channel SHALL run an independent FSM: IDLE, ON, OFF; channels share only i_Half_Period and i_Burst_Count.
REQ-014 IDLE with i_Start[n]=1 and i_Stop[n]=0 at edge k: latch H=i_Half_Period (H=0 treated as 1), B=i_Burst_Count, clear phase counter, enter ON.
REQ-015 o_Toggle[n] SHALL be 1 in ON and 0 in IDLE and OFF; first high cycle is the cycle after edge k.
REQ-016 ON SHALL last exactly H cycles, then OFF SHALL last exactly H cycles; phase counter is PERIOD_W bits, counts 0..H-1, resets on every phase change.
REQ-017 At end of OFF with B!=0: decrement remaining count; if it reaches 0, enter IDLE and pulse o_Done[n] for one cycle coincident with the first IDLE cycle; else enter ON.
REQ-018 With B=0 the channel SHALL alternate ON/OFF indefinitely and never assert o_Done.
REQ-019 i_Stop[n]=1 in any state SHALL force IDLE at next edge, o_Toggle[n]=0, o_Busy[n]=0, no o_Done pulse.
REQ-020 i_Start[n] and i_Stop[n] both high in the same cycle: stop wins.
REQ-021 i_Start[n] while ON or OFF (no stop) SHALL restart: relatch H and B, counter cleared, enter ON, no o_Done.
REQ-022 i_Start[n] in the same cycle the final OFF phase ends SHALL restart per REQ-021 and suppress that o_Done.
REQ-023 Changes on i_Half_Period/i_Burst_Count SHALL NOT affect a running channel until its next start.
REQ-024 o_Busy[n] SHALL be high in ON and OFF, low in IDLE.
REQ-025 H = 2^PERIOD_W-1 and B = 2^BURST_W-1 SHALL work without counter overflow.

Reset
REQ-026 i_Rst_L low SHALL immediately, without a clock, force all channels to IDLE, o_Toggle=0, o_Busy=0, o_Done=0, counters and latched values 0.
REQ-027 Reset asserted mid-burst SHALL abort without o_Done; after release the channel stays IDLE until a new i_Start.
REQ-028 First start SHALL be accepted on the first rising edge with i_Rst_L high.

Verification
REQ-029 Ch0: H=3, B=2, start pulse at edge 0 -> o_Toggle[0] 1 for cycles 1-3, 0 for 4-6, 1 for 7-9, 0 for 10-12; o_Done[0] high only in cycle 13; o_Busy[0] high cycles 1-12.
REQ-030 Ch1: H=0, B=0 -> o_Toggle[1] toggles every cycle indefinitely; i_Stop[1] at edge 20 -> o_Toggle[1]=0 and o_Busy[1]=0 from cycle 21, no o_Done.
REQ-031 Ch0 and ch2 started 5 cycles apart with H=4 and H=2 (inputs changed between starts) -> each channel keeps its own latched period; no cross-channel interaction.
REQ-032 Start and stop same cycle on IDLE and on busy channel -> channel IDLE next cycle, o_Toggle=0, no o_Done.
REQ-033 Start re-asserted during OFF of ch3 (H=5, B=3) -> ON restarts next cycle with full 3-blink burst, single o_Done only at true completion.
REQ-034 i_Rst_L low asynchronously mid-ON (between edges) -> all outputs 0 before the next edge; no o_Done after release.
